fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder buffer placed directly downstream of the 32-point FFT top.
//  - Consumes the FFT's serial output stream (finish, X_r, X_i), which carries bins in bit-reversed order.
//  - Re-emits each 32-sample frame in natural order (bin 0..31), tagging each sample with its bin index and a start-of-frame flag.
//  - Ping-pong: one bank fills while the other drains.
// PARAMETERS
//  N      32  points per frame (power of two)
//  LOG2N  5   index width
//  W      18  sample width, signed fixed point: 10 integer bits, 8 fractional bits
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  valid_i     in   1      input sample valid (driven by FFT finish)
//  data_in_r   in   W      real part, signed
//  data_in_i   in   W      imaginary part, signed
//  valid_o     out  1      output sample valid
//  sop_o       out  1      high with bin 0 of each output frame
//  index_o     out  LOG2N  natural-order bin index of current output
//  data_out_r  out  W      real part, signed
//  data_out_i  out  W      imaginary part, signed
//  mag_o       out  W+1    |re|+|im|, unsigned; present only with FFT_REORDER_MAG_EN
// BEHAVIOUR
//  Reset (synchronous, active-high, rst sampled at clk edge):
//  - Registered outputs: valid_o=0, sop_o=0, index_o=0, data_out_*=0, mag_o=0.
//  - Counters: wr_cnt=0, rd_cnt=0. Pointers: wr_bank=0.
//  - full[1:0]=0, rd_active=0.
//  - Bank RAM contents are not reset.
//  - Reset mid-frame discards the partial input frame and aborts any drain in progress.
//  Write side:
//  - On each edge with valid_i=1: store {r,i} to bank[wr_bank][bitrev(wr_cnt)], then wr_cnt++.
//  - When wr_cnt==N-1 is written: wr_cnt wraps to 0, full[wr_bank] is set, wr_bank toggles.
//  - Gaps in valid_i stall wr_cnt only. Frames are defined purely by counting valid samples.
//  Read FSM, states IDLE / DRAIN:
//  - IDLE -> DRAIN when full[rd_bank]=1.
//  - In DRAIN, one entry is read per cycle, rd_cnt = 0..N-1, from bank[rd_bank][rd_cnt].
//  - After rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt.
//    Stay in DRAIN if the other bank is full (seamless back-to-back frames); otherwise go to IDLE.
//  - Outputs are registered. The sample read at rd_cnt appears with valid_o=1, index_o=rd_cnt, sop_o=(rd_cnt==0).
//  Latency:
//  - Last input sample of a frame accepted at edge t -> bin 0 presented after edge t+1.
//  - Bins 1..31 follow on consecutive cycles, up to edge t+32.
//  Boundaries:
//  - Write to bank and set full on the same edge: the read of index 0 occurs the next cycle, so no bypass is needed.
//  - Drain (1 sample/cycle) is never slower than fill, so overflow is impossible.
//  - full[] is set and cleared on different banks on the same edge; both updates take effect.
//  - Continuous input: valid_o stays high continuously after the first frame; sop_o pulses every 32 cycles.
//  - Idle input: valid_o drops after the last frame drains, and outputs hold their last data.
// CONFIGURATION
//  FFT_REORDER_MAG_EN defined:
//  - Adds mag_o = |data_r| + |data_i|, computed on the RAM read data and registered with the other outputs (same latency).
//  - abs(-2^17) = 2^17 is exact in W+1 bits.
//  FFT_REORDER_MAG_EN undefined: the mag_o port and its logic are absent.
// STRUCTURE
//  - fft_pkg holds: N, LOG2N, W constants and function bitrev(LOG2N-bit) for shared use with the FFT stages.
//  - Sub-module fft_reorder_bank: N x 2W register array, one synchronous write port, combinational read.
//    Instantiated twice. The top holds the counters, full flags, FSM and output registers.
// TESTING
//  1. Single frame: feed r=k, i=-k for input slot k=0..31 (slot k holds bin bitrev(k)).
//     -> 32 outputs with index_o=n, data_out_r=bitrev(n), data_out_i=-bitrev(n); sop_o only at n=0.
//  2. Latency: last input at cycle 100 -> valid_o first high at cycle 101 with index_o=0;
//     valid_o low again at cycle 133.
//  3. Back-to-back: 4 continuous frames with distinct values.
//     -> 128 consecutive valid_o cycles, no bubbles; sop_o at cycles T, T+32, T+64, T+96.
//  4. Gapped input: valid_i high every 3rd cycle.
//     -> each frame drains as a contiguous burst, and data order is identical to test 1.
//  5. Reset mid-frame: rst high after 17 inputs, then a clean frame.
//     -> outputs all 0 and valid_o=0 during reset; only the clean frame emerges, correctly ordered.
//  6. MAG_EN: input (-131072, 131071) -> mag_o=262143; (-5, 3) -> mag_o=8.
//     Without the macro, the build elaborates with no mag_o port.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: constants and helpers shared by the 32-point FFT stages and
// the output reorder buffer.
//   N      points per frame
//   LOG2N  bin index width
//   W      sample width (signed, 10 integer / 8 fractional bits)
//   rd_state_e  read-side FSM states of the reorder buffer
//   bitrev()    reverses the LOG2N bits of a bin/slot index
//   abs_u()     magnitude of a signed W-bit sample as an unsigned W-bit value
package fft_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int W     = 18;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = x[LOG2N-1-b];
        end
        return r;
    endfunction

    // The most negative value maps to 2^(W-1), which is still representable
    // because the result is treated as unsigned.
    function automatic logic [W-1:0] abs_u(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one N-entry bank of the reorder ping-pong buffer.
// Storage is a plain register array (not reset); one synchronous write
// port and one combinational read port.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address (LOG2N bits)
//   wdata_i  write data {re, im}, 2*W bits
//   raddr_i  read address (LOG2N bits)
//   rdata_o  read data {re, im}, combinational from raddr_i
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [LOG2N-1:0]   waddr_i,
    input  logic [2*W-1:0]     wdata_i,
    input  logic [LOG2N-1:0]   raddr_i,
    output logic [2*W-1:0]     rdata_o
);

    logic [2*W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: output reorder buffer behind the 32-point FFT.
// The FFT emits bins in bit-reversed order; each input sample is written
// to slot bitrev(wr_cnt) of the filling bank, so a completed bank holds
// the frame in natural order and is drained linearly, one bin per cycle.
// Two banks ping-pong: one fills while the other drains.
//
// Optional feature macro: FFT_REORDER_MAG_EN adds mag_o = |re| + |im|.
//
// Handshake: valid_i qualifies data_in_* on each rising edge; there is no
// backpressure in either direction. valid_o qualifies sop_o, index_o and
// data_out_* (and mag_o) for exactly the cycle it is high; when valid_o
// is low the data outputs hold their last value.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             input sample valid (FFT finish)
//   data_in_r/_i        input sample, signed W bits
//   valid_o             output sample valid
//   sop_o               high with bin 0 of each output frame
//   index_o             natural-order bin index of the output
//   data_out_r/_i       output sample, signed W bits
//   mag_o               |re|+|im|, W+1 bits (FFT_REORDER_MAG_EN only)
//   state_o             read FSM state (debug observation)
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [W-1:0]     data_in_r,
    input  logic signed [W-1:0]     data_in_i,
    output logic                    valid_o,
    output logic                    sop_o,
    output logic [LOG2N-1:0]        index_o,
    output logic signed [W-1:0]     data_out_r,
    output logic signed [W-1:0]     data_out_i,
`ifdef FFT_REORDER_MAG_EN
    output logic [W:0]              mag_o,
`endif
    output rd_state_e               state_o
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Write side
    logic [LOG2N-1:0] wr_cnt_q;
    logic             wr_bank_q;
    logic             wr_last;
    logic [1:0]       bank_we;

    // Read side
    rd_state_e        state_q;
    logic [LOG2N-1:0] rd_cnt_q;
    logic             rd_bank_q;
    logic             rd_fire;
    logic             rd_last;

    logic [1:0]       full_q;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    logic [2*W-1:0]   wdata;
    logic [2*W-1:0]   rdata0;
    logic [2*W-1:0]   rdata1;
    logic [2*W-1:0]   rd_word;

    assign wdata   = {data_in_r, data_in_i};
    assign wr_last = valid_i && (wr_cnt_q == LAST_IDX);

    // IDLE performs the read of bin 0 itself as soon as the bank is full,
    // so bin 0 appears one edge after the frame's last write.
    assign rd_fire = (state_q == RD_DRAIN) || full_q[rd_bank_q];
    assign rd_last = (state_q == RD_DRAIN) && (rd_cnt_q == LAST_IDX);
    assign rd_word = rd_bank_q ? rdata1 : rdata0;

    always_comb begin
        bank_we  = '0;
        full_set = '0;
        full_clr = '0;
        if (valid_i && !rst) begin
            bank_we[wr_bank_q] = 1'b1;
        end
        if (wr_last) begin
            full_set[wr_bank_q] = 1'b1;
        end
        if (rd_last) begin
            full_clr[rd_bank_q] = 1'b1;
        end
    end

    fft_reorder_bank u_bank0 (
        .clk     (clk),
        .we_i    (bank_we[0]),
        .waddr_i (bitrev(wr_cnt_q)),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata0)
    );

    fft_reorder_bank u_bank1 (
        .clk     (clk),
        .we_i    (bank_we[1]),
        .waddr_i (bitrev(wr_cnt_q)),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata1)
    );

`ifdef FFT_REORDER_MAG_EN
    logic [W:0] mag_d;
    assign mag_d = {1'b0, abs_u(rd_word[2*W-1:W])} + {1'b0, abs_u(rd_word[W-1:0])};
`endif

    // Write counter, fill bank pointer and full flags. Set and clear always
    // target different banks, so both can apply on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            if (valid_i) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_last) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            full_q <= (full_q | full_set) & ~full_clr;
        end
    end

    // Read FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            valid_o    <= 1'b0;
            sop_o      <= 1'b0;
            index_o    <= '0;
            data_out_r <= '0;
            data_out_i <= '0;
`ifdef FFT_REORDER_MAG_EN
            mag_o      <= '0;
`endif
        end else begin
            if (rd_fire) begin
                valid_o    <= 1'b1;
                sop_o      <= (rd_cnt_q == '0);
                index_o    <= rd_cnt_q;
                data_out_r <= rd_word[2*W-1:W];
                data_out_i <= rd_word[W-1:0];
`ifdef FFT_REORDER_MAG_EN
                mag_o      <= mag_d;
`endif
            end else begin
                valid_o <= 1'b0;
                sop_o   <= 1'b0;
            end

            case (state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        state_q  <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_last) begin
                        rd_bank_q <= ~rd_bank_q;
                        // A frame that completes on this very edge is picked
                        // up from IDLE next cycle without a bubble.
                        state_q   <= full_q[~rd_bank_q] ? RD_DRAIN : RD_IDLE;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

    localparam int EW = 1 + 5 + 18 + 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic signed [17:0] data_in_r;
    logic signed [17:0] data_in_i;
    logic               valid_o;
    logic               sop_o;
    logic [4:0]         index_o;
    logic signed [17:0] data_out_r;
    logic signed [17:0] data_out_i;
`ifdef FFT_REORDER_MAG_EN
    logic [18:0]        mag_o;
    logic [18:0]        mag_q[$];
`endif
    fft_pkg::rd_state_e state_o;

    logic [EW-1:0] exp_q[$];
    int            sop_cyc_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            run_cnt = 0;
    int            last_run = 0;

    // Hand-written 5-bit bit-reversal table.
    int br_tab[32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                       1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    fft_bitrev_reorder dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .sop_o      (sop_o),
        .index_o    (index_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
`ifdef FFT_REORDER_MAG_EN
        .mag_o      (mag_o),
`endif
        .state_o    (state_o)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] pack(input bit sop, input int idx, input int r, input int i);
        return {sop, 5'(idx), 18'(r), 18'(i)};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Driver tasks
    task automatic send_sample(input int r, input int i);
        @(negedge clk);
        valid_i   = 1'b1;
        data_in_r = 18'(r);
        data_in_i = 18'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic send_frame_arr(input int r_in[32], input int i_in[32], input int gap);
        for (int n = 0; n < 32; n++) begin
            exp_q.push_back(pack(n == 0, n, r_in[br_tab[n]], i_in[br_tab[n]]));
`ifdef FFT_REORDER_MAG_EN
            mag_q.push_back(19'(iabs(r_in[br_tab[n]]) + iabs(i_in[br_tab[n]])));
`endif
        end
        for (int k = 0; k < 32; k++) begin
            send_sample(r_in[k], i_in[k]);
            if (gap > 0) idle(gap);
        end
    endtask

    // Slot k carries r = base_r + k, i = base_i - k.
    task automatic send_ramp(input int base_r, input int base_i, input int gap);
        int r_in[32];
        int i_in[32];
        for (int k = 0; k < 32; k++) begin
            r_in[k] = base_r + k;
            i_in[k] = base_i - k;
        end
        send_frame_arr(r_in, i_in, gap);
    endtask

    // Scoreboard monitor: pops one expected entry per valid output.
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                run_cnt++;
                if (sop_o) sop_cyc_q.push_back(cyc);
                got = {sop_o, index_o, data_out_r, data_out_i};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%0h (cycle %0d)", got, cyc);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sample got sop=%0b idx=%0d r=%0d i=%0d exp sop=%0b idx=%0d r=%0d i=%0d (cycle %0d)",
                                 got[41], got[40:36], $signed(got[35:18]), $signed(got[17:0]),
                                 exp[41], exp[40:36], $signed(exp[35:18]), $signed(exp[17:0]), cyc);
                    end
                end
`ifdef FFT_REORDER_MAG_EN
                checks++;
                if (mag_q.size() == 0) begin
                    errors++;
                    $display("FAIL mag_unexpected got=%0d", mag_o);
                end else begin
                    logic [18:0] em;
                    em = mag_q.pop_front();
                    if (mag_o !== em) begin
                        errors++;
                        $display("FAIL mag got=%0d exp=%0d (cycle %0d)", mag_o, em, cyc);
                    end
                end
`endif
            end else if (run_cnt != 0) begin
                last_run = run_cnt;
                run_cnt  = 0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        valid_i   = 1'b0;
        data_in_r = '0;
        data_in_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_sop", 64'(sop_o), 64'd0);
        check("rst_index", 64'(index_o), 64'd0);
        check("rst_data_r", 64'(data_out_r), 64'd0);
        check("rst_data_i", 64'(data_out_i), 64'd0);
        check("rst_state", 64'(state_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Single frame r=k, i=-k, with latency checks around the last input
        send_ramp(0, 0, 0);
        @(negedge clk);               // after the edge that took the last input
        valid_i = 1'b0;
        check("lat_not_yet", 64'(valid_o), 64'd0);
        @(negedge clk);               // one edge later: bin 0
        check("lat_first_valid", 64'(valid_o), 64'd1);
        check("lat_first_index", 64'(index_o), 64'd0);
        check("lat_first_sop", 64'(sop_o), 64'd1);
        repeat (31) @(negedge clk);
        check("lat_last_valid", 64'(valid_o), 64'd1);
        check("lat_last_index", 64'(index_o), 64'd31);
        @(negedge clk);
        check("lat_drop_valid", 64'(valid_o), 64'd0);
        check("hold_data_r", 64'(data_out_r), 64'(18'd31));
        check("hold_data_i", 64'(data_out_i), 64'(-18'sd31));
        idle(5);

        // Back-to-back frames
        sop_cyc_q.delete();
        send_ramp(100, -100, 0);
        send_ramp(2000, -3000, 0);
        send_ramp(-7000, 50, 0);
        send_ramp(30000, -60000, 0);
        idle(50);
        check("b2b_run_len", 64'(last_run), 64'd128);
        check("b2b_sop_count", 64'(sop_cyc_q.size()), 64'd4);
        if (sop_cyc_q.size() == 4) begin
            for (int s = 1; s < 4; s++) begin
                check("b2b_sop_spacing", 64'(sop_cyc_q[s] - sop_cyc_q[s-1]), 64'd32);
            end
        end

        // Gapped input: valid_i every third cycle
        send_ramp(500, 600, 2);
        send_ramp(-42, 77, 2);
        idle(50);
        check("gap_burst_len", 64'(last_run), 64'd32);

        // Reset while a drain is running and a partial frame is filling
        send_ramp(1000, -500, 0);
        for (int k = 0; k < 17; k++) send_sample(9000 + k, -9000 - k);
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
`ifdef FFT_REORDER_MAG_EN
        mag_q.delete();
`endif
        @(negedge clk);
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_data_r", 64'(data_out_r), 64'd0);
        check("mid_rst_data_i", 64'(data_out_i), 64'd0);
        check("mid_rst_index", 64'(index_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send_ramp(200, 300, 0);
        idle(50);

`ifdef FFT_REORDER_MAG_EN
        begin
            int r_in[32];
            int i_in[32];
            for (int k = 0; k < 32; k++) begin
                r_in[k] = 0;
                i_in[k] = 0;
            end
            r_in[0] = -131072; i_in[0] = 131071;   // bin 0 -> 262143
            r_in[1] = -5;      i_in[1] = 3;        // bin 16 -> 8
            send_frame_arr(r_in, i_in, 0);
            idle(3);
            repeat (28) @(negedge clk);
        end
`endif

        // Drain whatever remains, bounded
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
